// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller_if
// Description : Bundles the CPU load/store signals and the block memory bus
//               of the data cache controller.
//               slave  - cache controller view (CPU requests and memory
//                        responses in; load data, stall, block requests out)
//               master - environment view (CPU plus memory)
// Signals     : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0], READDATA[7:0],
//               BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS[5:0],
//               MEM_WRITEDATA[31:0], MEM_READDATA[31:0], MEM_BUSYWAIT
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_controller_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
               MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
               MEM_WRITEDATA
    );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate data cache with
//               8 lines of 4 bytes. Hits complete with no stall; misses run
//               an optional block write-back followed by a block refill while
//               BUSYWAIT freezes the CPU.
// Ports       : CLK   - clock, all state changes on posedge
//               RESET - synchronous active-high, clears valid/dirty and FSM
//               bus   - dcache_controller_if.slave (CPU side + memory side)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller (
    input  wire logic          CLK,
    input  wire logic          RESET,
    dcache_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;
    logic [2:0]  r_tag  [8];
    logic [31:0] r_data [8];
    logic [31:0] r_refill;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [5:0]  r_mem_address;
    logic [31:0] r_mem_writedata;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic        w_req;
    logic        w_hit;
    logic        w_write_hit;
    logic [31:0] w_line;
    logic [7:0]  w_byte;

    assign w_tag    = bus.ADDRESS[7:5];
    assign w_index  = bus.ADDRESS[4:2];
    assign w_offset = bus.ADDRESS[1:0];
    assign w_req    = bus.READ | bus.WRITE;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_line   = r_data[w_index];

    // A store wins over a load when both are requested.
    assign w_write_hit = (r_state == IDLE) && bus.WRITE && w_hit;

    always_comb begin
        w_byte = 8'h00;
        case (w_offset)
            2'd0: w_byte = w_line[7:0];
            2'd1: w_byte = w_line[15:8];
            2'd2: w_byte = w_line[23:16];
            2'd3: w_byte = w_line[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign bus.READDATA      = (bus.READ && w_hit && (r_state == IDLE)) ? w_byte : 8'h00;
    // The miss stall must appear in the same cycle as the request, so the
    // IDLE term is combinational; every other state stalls unconditionally.
    assign bus.BUSYWAIT      = (r_state != IDLE) || (w_req && !w_hit);
    assign bus.MEM_READ      = r_mem_read;
    assign bus.MEM_WRITE     = r_mem_write;
    assign bus.MEM_ADDRESS   = r_mem_address;
    assign bus.MEM_WRITEDATA = r_mem_writedata;

    // Controller FSM. Memory request outputs are registered and set up on the
    // transition into the state that owns them, so they are valid for every
    // cycle of WRITEBACK/REFILL and drop the cycle after leaving.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_valid         <= 8'h00;
            r_dirty         <= 8'h00;
            r_refill        <= 32'h0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= 6'h00;
            r_mem_writedata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (bus.WRITE) begin
                                r_dirty[w_index] <= 1'b1;
                            end
                        end else if (r_dirty[w_index]) begin
                            r_state         <= WRITEBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {r_tag[w_index], w_index};
                            r_mem_writedata <= w_line;
                        end else begin
                            r_state       <= REFILL;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= bus.ADDRESS[7:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        r_state       <= REFILL;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= bus.ADDRESS[7:2];
                    end
                end
                REFILL: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        r_state    <= UPDATE;
                        r_mem_read <= 1'b0;
                        r_refill   <= bus.MEM_READDATA;
                    end
                end
                UPDATE: begin
                    r_state          <= IDLE;
                    r_valid[w_index] <= 1'b1;
                    r_dirty[w_index] <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage. Tags and data have no reset; only valid/dirty qualify
    // them. An edge carrying RESET writes nothing, so an aborted refill never
    // reaches the array.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == UPDATE) begin
                r_data[w_index] <= r_refill;
                r_tag[w_index]  <= w_tag;
            end else if (w_write_hit) begin
                r_data[w_index][{w_offset, 3'b000} +: 8] <= bus.WRITEDATA;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed self-checking bench for dcache_controller with a
//               fixed-latency block memory model (L = 5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    localparam int c_LAT = 5;

    logic CLK;
    logic RESET;

    dcache_controller_if bus ();

    dcache_controller dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- memory model ----------------
    logic [31:0] mem [64];
    logic        r_loaded = 1'b0;
    int          mcnt     = 0;
    logic        w_mreq;

    assign w_mreq           = bus.MEM_READ | bus.MEM_WRITE;
    assign bus.MEM_BUSYWAIT = w_mreq && (mcnt != c_LAT - 1);
    assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!r_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[6'h05] <= 32'h44332211;
            mem[6'h0D] <= 32'hDDCCBBAA;
            mem[6'h38] <= 32'h87654321;
            mem[6'h18] <= 32'h0F0E0D0C;
            r_loaded   <= 1'b1;
        end else if (RESET) begin
            mcnt <= 0;
        end else if (w_mreq) begin
            if (mcnt == c_LAT - 1) begin
                mcnt <= 0;
                if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    logic        saw_rd, saw_wr, order_bad, both_hi;
    logic [5:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    int          nb;
    logic [7:0]  rdata;
    int          refill_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        saw_rd    = 1'b0;
        saw_wr    = 1'b0;
        order_bad = 1'b0;
        rd_addr   = 6'h00;
        wr_addr   = 6'h00;
        wr_data   = 32'h0;
    endtask

    task automatic record_mem();
        if (bus.MEM_READ && bus.MEM_WRITE) both_hi = 1'b1;
        if (bus.MEM_WRITE) begin
            if (saw_rd) order_bad = 1'b1;
            saw_wr  = 1'b1;
            wr_addr = bus.MEM_ADDRESS;
            wr_data = bus.MEM_WRITEDATA;
        end
        if (bus.MEM_READ) begin
            saw_rd  = 1'b1;
            rd_addr = bus.MEM_ADDRESS;
        end
    endtask

    // Presents one access after a posedge, counts the negedges with BUSYWAIT
    // high, captures READDATA in the first cycle the stall is gone, then lets
    // one more edge complete the access before dropping the request.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, output int n, output logic [7:0] q);
        @(posedge CLK);
        #1;
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = a;
        bus.WRITEDATA = d;
        clear_mon();
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            record_mem();
            if (!bus.BUSYWAIT) break;
            n++;
        end
        q = bus.READDATA;
        @(posedge CLK);
        #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        both_hi       = 1'b0;
        RESET         = 1'b1;
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = 8'h00;
        bus.WRITEDATA = 8'h00;
        clear_mon();
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_busywait", {31'h0, bus.BUSYWAIT},  32'h0);
        chk("rst_mem_read", {31'h0, bus.MEM_READ},  32'h0);
        chk("rst_mem_write",{31'h0, bus.MEM_WRITE}, 32'h0);
        chk("rst_readdata", {24'h0, bus.READDATA},  32'h0);

        // Cold read miss at 0x14
        do_access(1'b1, 1'b0, 8'h14, 8'h00, nb, rdata);
        chk("cold_busy_cycles", nb, 7);
        chk("cold_saw_rd", {31'h0, saw_rd}, 32'h1);
        chk("cold_rd_addr", {26'h0, rd_addr}, 32'h05);
        chk("cold_saw_wr", {31'h0, saw_wr}, 32'h0);
        chk("cold_readdata", {24'h0, rdata}, 32'h11);

        // Read hit at 0x17
        do_access(1'b1, 1'b0, 8'h17, 8'h00, nb, rdata);
        chk("hit_busy_cycles", nb, 0);
        chk("hit_readdata", {24'h0, rdata}, 32'h44);
        chk("hit_saw_rd", {31'h0, saw_rd}, 32'h0);

        // Write hit 0xAB -> 0x15
        do_access(1'b0, 1'b1, 8'h15, 8'hAB, nb, rdata);
        chk("wrhit_busy_cycles", nb, 0);

        // Dirty eviction by READ 0x35
        do_access(1'b1, 1'b0, 8'h35, 8'h00, nb, rdata);
        chk("evict_busy_cycles", nb, 12);
        chk("evict_saw_wr", {31'h0, saw_wr}, 32'h1);
        chk("evict_wr_addr", {26'h0, wr_addr}, 32'h05);
        chk("evict_wr_data", wr_data, 32'h4433AB11);
        chk("evict_rd_addr", {26'h0, rd_addr}, 32'h0D);
        chk("evict_order", {31'h0, order_bad}, 32'h0);
        chk("evict_readdata", {24'h0, rdata}, 32'hBB);

        // Write miss allocate: 0x5A -> 0xE2
        do_access(1'b0, 1'b1, 8'hE2, 8'h5A, nb, rdata);
        chk("wmiss_busy_cycles", nb, 7);
        chk("wmiss_saw_wr", {31'h0, saw_wr}, 32'h0);
        chk("wmiss_rd_addr", {26'h0, rd_addr}, 32'h38);
        do_access(1'b1, 1'b0, 8'hE2, 8'h00, nb, rdata);
        chk("wmiss_rdback_busy", nb, 0);
        chk("wmiss_rdback_data", {24'h0, rdata}, 32'h5A);

        // Bring block 0x05 back (clean miss) and confirm the written-back byte
        do_access(1'b1, 1'b0, 8'h17, 8'h00, nb, rdata);
        chk("reload_busy_cycles", nb, 7);
        chk("reload_saw_wr", {31'h0, saw_wr}, 32'h0);
        chk("reload_readdata", {24'h0, rdata}, 32'h44);
        do_access(1'b1, 1'b0, 8'h15, 8'h00, nb, rdata);
        chk("reload_wb_byte", {24'h0, rdata}, 32'hAB);

        // READ and WRITE together on a hit: treated as a store
        do_access(1'b1, 1'b1, 8'h17, 8'h99, nb, rdata);
        chk("rw_busy_cycles", nb, 0);
        do_access(1'b1, 1'b0, 8'h17, 8'h00, nb, rdata);
        chk("rw_readback", {24'h0, rdata}, 32'h99);

        // Reset mid-refill: READ 0x60 evicts dirty line 0 (tag 7) first
        @(posedge CLK);
        #1;
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h60;
        clear_mon();
        refill_cycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            record_mem();
            if (bus.MEM_READ) begin
                refill_cycles++;
                if (refill_cycles == 3) break;
            end
        end
        chk("rstmid_refill_cycles", refill_cycles, 3);
        chk("rstmid_wr_addr", {26'h0, wr_addr}, 32'h38);
        chk("rstmid_wr_data", wr_data, 32'h875A4321);
        chk("rstmid_rd_addr", {26'h0, rd_addr}, 32'h18);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        bus.READ = 1'b0;
        @(negedge CLK);
        chk("rstmid_mem_read", {31'h0, bus.MEM_READ}, 32'h0);
        chk("rstmid_mem_write", {31'h0, bus.MEM_WRITE}, 32'h0);
        chk("rstmid_idle", {31'h0, bus.BUSYWAIT}, 32'h0);
        chk("rstmid_readdata", {24'h0, bus.READDATA}, 32'h0);
        do_access(1'b1, 1'b0, 8'h60, 8'h00, nb, rdata);
        chk("rstmid_remiss_busy", nb, 7);
        chk("rstmid_remiss_saw_wr", {31'h0, saw_wr}, 32'h0);
        chk("rstmid_remiss_data", {24'h0, rdata}, 32'h0C);

        chk("never_both_req", {31'h0, both_hi}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store path and a slow 32-bit-block data memory. Holds 8 lines of 4 bytes each, serves hits with no stall, and sequences block write-back and refill on misses. While a miss is serviced it holds BUSYWAIT high to freeze the CPU (PC and register-file write).

## Interface
Parameters:
- none (geometry fixed: 8-bit byte address, 8 lines, 4-byte blocks)

Ports:
- CLK  in  1  system clock; all state updates on posedge
- RESET  in  1  synchronous, active-high
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  8  byte address: tag [7:5], index [4:2], offset [1:0]
- WRITEDATA  in  8  store data
- READDATA  out  8  load data; valid when READ=1 and BUSYWAIT=0
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block read request to memory
- MEM_WRITE  out  1  block write request to memory
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  block being written back, byte 0 in [7:0]
- MEM_READDATA  in  32  refill block, byte 0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy; transfer completes at the first posedge where it is sampled low while a request is asserted

## Operation
- Per line state: valid, dirty, 3-bit tag, 32-bit data. RESET clears all valid and dirty bits. Data and tags are unchanged.
- hit = valid[index] && tag[index]==ADDRESS[7:5]. If READ and WRITE are both high, the access is treated as a write.
- FSM states: IDLE, WRITEBACK, REFILL, UPDATE.
- IDLE, no request: BUSYWAIT=0, no memory request.
- IDLE, read hit: READDATA = selected byte, combinational. BUSYWAIT=0.
- IDLE, write hit: BUSYWAIT=0. At the next posedge, the byte is written and dirty is set.
- IDLE, miss on a clean or invalid line: BUSYWAIT=1 combinationally in the same cycle. Next state is REFILL.
- IDLE, miss on a dirty line: BUSYWAIT=1. Next state is WRITEBACK.
- WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data. When MEM_BUSYWAIT is sampled low, next state is REFILL.
- REFILL: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]. When MEM_BUSYWAIT is sampled low, capture MEM_READDATA into a refill register. Next state is UPDATE.
- UPDATE: write the refill block into the line, set tag, set valid=1, clear dirty. Next state is IDLE. BUSYWAIT stays 1.
- Back in IDLE, the held request now hits and completes as a normal hit. A write sets dirty at that edge.
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE and UPDATE.
- In all states other than IDLE, BUSYWAIT=1.

## Timing
- Reset: after the RESET edge, state=IDLE, BUSYWAIT=0 (absent a request), MEM_READ=0, MEM_WRITE=0, READDATA=0 when READ=0.
- RESET asserted mid-operation (any state) aborts the operation at that edge. Memory requests drop in the following cycle, and no line is updated by the aborted refill.
- Hit latency: 0 stall cycles.
- Clean miss, memory latency L cycles (MEM_BUSYWAIT high for L-1 cycles): BUSYWAIT high for L+2 cycles, counted as 1 IDLE cycle + L REFILL cycles + 1 UPDATE cycle.
- Dirty miss: add L cycles for WRITEBACK.
- Memory inputs are sampled only in WRITEBACK and REFILL. MEM_BUSYWAIT glitches in other states are ignored.
- Address, data and request lines must stay stable while BUSYWAIT=1. Behaviour on violation is undefined.

## Test plan
- Cold read miss: RESET, then READ addr 0x14 with memory block 0x44332211 and L=5. BUSYWAIT must be high for 7 cycles and MEM_READ must be asserted with MEM_ADDRESS=0x05. READDATA=0x11 on the first cycle BUSYWAIT is low.
- Read hit: READ 0x17 immediately after the previous test. BUSYWAIT stays 0, READDATA=0x44, no MEM_READ.
- Write hit then dirty eviction:
  - WRITE 0xAB to 0x15, with zero stall.
  - Then READ 0x35 (same index, tag 1). MEM_WRITE must be asserted with MEM_ADDRESS=0x05 and MEM_WRITEDATA=0x4433AB11, followed by a refill from MEM_ADDRESS=0x0D.
- Write miss allocate: WRITE 0x5A to 0xE2 on an invalid line. The line is refilled, then byte 2 of the line becomes 0x5A with dirty set. A subsequent READ 0xE2 hits and returns 0x5A.
- Reset mid-refill: assert RESET during REFILL cycle 3. MEM_READ must be 0 by the following cycle and the state must be IDLE. A READ to the same address then misses again.
- Simultaneous READ and WRITE on a hit at 0x17 with WRITEDATA 0x99: the access is treated as a store, and a later READ 0x17 returns 0x99.
